// File: rtl/decrypt_sequencer_if.sv
// Handshake and memory bus between decrypt_sequencer and its neighbours:
// receiver control (start/seed/busy/done), keystream generator and pixel BRAMs.
// Optional macro DECRYPT_SEQ_STALL_CNT_EN adds the stall_cnt observation signal.
interface decrypt_sequencer_if #(
    parameter int ADDR_W = 14,
    parameter int SEED_W = 32
);
    logic              start;
    logic [SEED_W-1:0] seed_in;
    logic              seed_load;
    logic [SEED_W-1:0] seed_out;
    logic              ks_valid;
    logic              ks_ready;
    logic [7:0]        ks_r;
    logic [7:0]        ks_g;
    logic [7:0]        ks_b;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_r;
    logic [7:0]        mem_rd_g;
    logic [7:0]        mem_rd_b;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wr_r;
    logic [7:0]        mem_wr_g;
    logic [7:0]        mem_wr_b;
    logic              busy;
    logic              done;
`ifdef DECRYPT_SEQ_STALL_CNT_EN
    logic [15:0]       stall_cnt;

    modport master (
        input  start, seed_in, ks_valid, ks_r, ks_g, ks_b,
               mem_rd_r, mem_rd_g, mem_rd_b,
        output seed_load, seed_out, ks_ready, mem_rd_en, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_r, mem_wr_g, mem_wr_b,
               busy, done, stall_cnt
    );

    modport slave (
        output start, seed_in, ks_valid, ks_r, ks_g, ks_b,
               mem_rd_r, mem_rd_g, mem_rd_b,
        input  seed_load, seed_out, ks_ready, mem_rd_en, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_r, mem_wr_g, mem_wr_b,
               busy, done, stall_cnt
    );
`else
    modport master (
        input  start, seed_in, ks_valid, ks_r, ks_g, ks_b,
               mem_rd_r, mem_rd_g, mem_rd_b,
        output seed_load, seed_out, ks_ready, mem_rd_en, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_r, mem_wr_g, mem_wr_b,
               busy, done
    );

    modport slave (
        output start, seed_in, ks_valid, ks_r, ks_g, ks_b,
               mem_rd_r, mem_rd_g, mem_rd_b,
        input  seed_load, seed_out, ks_ready, mem_rd_en, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_r, mem_wr_g, mem_wr_b,
               busy, done
    );
`endif
endinterface

// File: rtl/decrypt_sequencer.sv
// Frame decryption sequencer: seeds the keystream generator, discards WARMUP
// warm-up words, then reads each encrypted pixel, XORs it with one keystream
// word and writes it to the decrypted memory, addresses 0..DEPTH-1 ascending.
// Optional macro DECRYPT_SEQ_STALL_CNT_EN adds a saturating keystream stall counter.
module decrypt_sequencer #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384,
    parameter int WARMUP = 64,
    parameter int SEED_W = 32
) (
    input  logic clk,
    input  logic rst,
    decrypt_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_WARM,
        S_RD,
        S_XOR,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam int                WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    // Unused when WARMUP==0 because the WARM state is never entered then.
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [WARM_W-1:0] warm_cnt, warm_cnt_nxt;
    logic [SEED_W-1:0] seed_q;
    logic              ks_hs;
    logic              start_acc;

    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [7:0]        wr_r_p1, wr_g_p1, wr_b_p1;

    assign bus.ks_ready = (state == S_WARM) || (state == S_XOR);
    assign ks_hs        = bus.ks_valid && bus.ks_ready;
    assign start_acc    = bus.start && ((state == S_IDLE) || (state == S_DONE));

    assign bus.seed_out    = seed_q;
    assign bus.mem_wr_en   = wr_vld_p1;
    assign bus.mem_wr_addr = wr_addr_p1;
    assign bus.mem_wr_r    = wr_r_p1;
    assign bus.mem_wr_g    = wr_g_p1;
    assign bus.mem_wr_b    = wr_b_p1;

    // State, address and warm-up counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            warm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            warm_cnt <= warm_cnt_nxt;
        end
    end

    // Next-state decode; start is honoured only in IDLE and DONE.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        warm_cnt_nxt = warm_cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_SEED;
            end
            S_SEED: begin
                addr_nxt     = '0;
                warm_cnt_nxt = '0;
                state_nxt    = (WARMUP > 0) ? S_WARM : S_RD;
            end
            S_WARM: begin
                if (ks_hs) begin
                    warm_cnt_nxt = warm_cnt + WARM_W'(1);
                    if (warm_cnt == WARM_LAST) state_nxt = S_RD;
                end
            end
            S_RD: begin
                state_nxt = S_XOR;
            end
            S_XOR: begin
                if (ks_hs) begin
                    // Never step past the last address, even when DEPTH fills the address space.
                    if (addr == LAST_ADDR) begin
                        state_nxt = S_DONE;
                    end else begin
                        addr_nxt  = addr + ADDR_W'(1);
                        state_nxt = S_RD;
                    end
                end
            end
            S_DONE: begin
                if (bus.start) state_nxt = S_SEED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered control outputs, decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q          <= '0;
            bus.seed_load   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
        end else begin
            if (start_acc) seed_q <= bus.seed_in;
            bus.seed_load <= (state_nxt == S_SEED);
            bus.busy      <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            bus.done      <= (state_nxt == S_DONE);
            bus.mem_rd_en <= (state_nxt == S_RD);
            if (state_nxt == S_RD) bus.mem_rd_addr <= addr_nxt;
        end
    end

    // ---- stage p1: XOR result registered one cycle after the keystream handshake ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_r_p1    <= '0;
            wr_g_p1    <= '0;
            wr_b_p1    <= '0;
        end else begin
            wr_vld_p1 <= (state == S_XOR) && ks_hs;
            if ((state == S_XOR) && ks_hs) begin
                wr_addr_p1 <= addr;
                wr_r_p1    <= bus.mem_rd_r ^ bus.ks_r;
                wr_g_p1    <= bus.mem_rd_g ^ bus.ks_g;
                wr_b_p1    <= bus.mem_rd_b ^ bus.ks_b;
            end
        end
    end

`ifdef DECRYPT_SEQ_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_q;
    assign bus.stall_cnt = stall_q;

    // Count XOR cycles spent waiting on the keystream; frozen outside XOR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state == S_SEED) begin
            stall_q <= '0;
        end else if ((state == S_XOR) && !bus.ks_valid) begin
            stall_q <= sat_inc16(stall_q);
        end
    end
`endif

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Directed bench for decrypt_sequencer: DEPTH=4 frames with WARMUP=2 (full
// 2-bit address space) and WARMUP=0, stall, restart, ignored start and reset.
module tb_decrypt_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decrypt_sequencer_if #(.ADDR_W(2), .SEED_W(32)) if0 ();
    decrypt_sequencer_if #(.ADDR_W(3), .SEED_W(32)) if1 ();

    decrypt_sequencer #(.ADDR_W(2), .DEPTH(4), .WARMUP(2), .SEED_W(32)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );

    decrypt_sequencer #(.ADDR_W(3), .DEPTH(4), .WARMUP(0), .SEED_W(32)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] mem_r [0:3] = '{8'hA0, 8'hA1, 8'hA5, 8'hA3};
    logic [7:0] ks_n0, ks_n1;
    logic       ks_r5a;

    // encrypted memories: 1-cycle read latency, data held between reads
    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        if (if0.mem_rd_en) begin
            if0.mem_rd_r <= mem_r[if0.mem_rd_addr];
            if0.mem_rd_g <= 8'h30 + 8'(if0.mem_rd_addr);
            if0.mem_rd_b <= 8'hC0 + 8'(if0.mem_rd_addr);
        end
        if (if1.mem_rd_en) begin
            if1.mem_rd_r <= mem_r[if1.mem_rd_addr[1:0]];
            if1.mem_rd_g <= 8'h30 + 8'(if1.mem_rd_addr);
            if1.mem_rd_b <= 8'hC0 + 8'(if1.mem_rd_addr);
        end
    end

    // keystream sources: word n carries bytes 8'h10+n
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_n0 <= 8'd0;
            ks_n1 <= 8'd0;
        end else begin
            if (if0.ks_valid && if0.ks_ready) ks_n0 <= ks_n0 + 8'd1;
            if (if1.ks_valid && if1.ks_ready) ks_n1 <= ks_n1 + 8'd1;
        end
    end
    assign if0.ks_r = ks_r5a ? 8'h5A : 8'h10 + ks_n0;
    assign if0.ks_g = 8'h10 + ks_n0;
    assign if0.ks_b = 8'h10 + ks_n0;
    assign if1.ks_r = 8'h10 + ks_n1;
    assign if1.ks_g = 8'h10 + ks_n1;
    assign if1.ks_b = 8'h10 + ks_n1;

    // write / strobe logs
    logic [1:0] wl_addr [0:15];
    logic [7:0] wl_r [0:15];
    logic [7:0] wl_g [0:15];
    logic [7:0] wl_b [0:15];
    int         wl_cyc [0:15];
    int         wn0 = 0;
    int         sl_cnt0 = 0;
    int         ov0 = 0;
    logic [2:0] f1_addr;
    logic [7:0] f1_r, f1_g, f1_b;
    int         wn1 = 0;

    always @(negedge clk) begin
        if (if0.mem_wr_en && wn0 < 16) begin
            wl_addr[wn0] <= if0.mem_wr_addr;
            wl_r[wn0]    <= if0.mem_wr_r;
            wl_g[wn0]    <= if0.mem_wr_g;
            wl_b[wn0]    <= if0.mem_wr_b;
            wl_cyc[wn0]  <= cyc;
            wn0          <= wn0 + 1;
        end
        if (if0.mem_wr_en && if0.mem_rd_en && (if0.mem_wr_addr == if0.mem_rd_addr)) ov0 <= ov0 + 1;
        if (if0.seed_load) sl_cnt0 <= sl_cnt0 + 1;
        if (if1.mem_wr_en) begin
            if (wn1 == 0) begin
                f1_addr <= if1.mem_wr_addr;
                f1_r    <= if1.mem_wr_r;
                f1_g    <= if1.mem_wr_g;
                f1_b    <= if1.mem_wr_b;
            end
            wn1 <= wn1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [7:0] exp_r1 [0:3] = '{8'hB2, 8'hB2, 8'hB1, 8'hB6};
    logic [7:0] exp_g1 [0:3] = '{8'h22, 8'h22, 8'h26, 8'h26};
    logic [7:0] exp_b1 [0:3] = '{8'hD2, 8'hD2, 8'hD6, 8'hD6};

    initial begin
        int t0;
        int wbase;
        rst = 1'b1;
        ks_r5a = 1'b0;
        if0.start = 1'b0; if0.seed_in = '0; if0.ks_valid = 1'b1;
        if1.start = 1'b0; if1.seed_in = '0; if1.ks_valid = 1'b1;
        step();
        step();
        chk("rst_seed_load", if0.seed_load, 0);
        chk("rst_seed_out",  if0.seed_out, 0);
        chk("rst_busy",      if0.busy, 0);
        chk("rst_done",      if0.done, 0);
        chk("rst_ks_ready",  if0.ks_ready, 0);
        chk("rst_rd_en",     if0.mem_rd_en, 0);
        chk("rst_wr_en",     if0.mem_wr_en, 0);
        chk("rst_rd_addr",   if0.mem_rd_addr, 0);
        rst = 1'b0;
        step();

        // frame 1: WARMUP=2, plus a start pulse mid-frame that must be ignored
        if0.seed_in = 32'hDEADBEEF;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        t0 = cyc;
        chk("f1_seed_load", if0.seed_load, 1);
        chk("f1_seed_out",  if0.seed_out, 32'hDEADBEEF);
        chk("f1_busy",      if0.busy, 1);
        step();
        chk("f1_seed_load_pulse", if0.seed_load, 0);
        chk("f1_warm_ready",      if0.ks_ready, 1);
        if0.seed_in = 32'h12345678;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int i = 0; i < 50 && !if0.done; i++) step();
        chk("f1_done",      if0.done, 1);
        chk("f1_busy_done", if0.busy, 0);
        chk("f1_cycles",    cyc - t0, 11);
        chk("f1_wr_count",  wn0, 4);
        chk("f1_seed_pulses", sl_cnt0, 1);
        chk("f1_last_wr_in_done", wl_cyc[3], cyc);
        for (int a = 0; a < 4; a++) begin
            chk("f1_wr_addr", wl_addr[a], a);
            chk("f1_wr_r",    wl_r[a], exp_r1[a]);
            chk("f1_wr_g",    wl_g[a], exp_g1[a]);
            chk("f1_wr_b",    wl_b[a], exp_b1[a]);
        end

        // frame 2: restart from DONE, ks_r fixed at 5A, 3-cycle stall at addr 1
        ks_r5a = 1'b1;
        if0.seed_in = 32'hCAFEF00D;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        chk("f2_done_drops", if0.done, 0);
        chk("f2_seed_load",  if0.seed_load, 1);
        chk("f2_seed_out",   if0.seed_out, 32'hCAFEF00D);
        for (int i = 0; i < 50 && !(if0.mem_rd_en && if0.mem_rd_addr == 2'd1); i++) step();
        chk("f2_reach_rd1", if0.mem_rd_en && (if0.mem_rd_addr == 2'd1), 1);
        if0.ks_valid = 1'b0;
        repeat (4) step();
        chk("f2_no_wr_stall", wn0, 5);
        chk("f2_wr_en_stall", if0.mem_wr_en, 0);
`ifdef DECRYPT_SEQ_STALL_CNT_EN
        chk("f2_stall_cnt", if0.stall_cnt, 3);
`endif
        if0.ks_valid = 1'b1;
        step();
        chk("f2_wr_after_stall", if0.mem_wr_en, 1);
        chk("f2_wr_addr1",       if0.mem_wr_addr, 1);
        for (int i = 0; i < 50 && !if0.done; i++) step();
        chk("f2_done",      if0.done, 1);
        chk("f2_wr_count",  wn0, 8);
        chk("f2_first_addr", wl_addr[4], 0);
        chk("f2_r_addr0",   wl_r[4], 8'hFA);
        chk("f2_addr2",     wl_addr[6], 2);
        chk("f2_r_addr2",   wl_r[6], 8'hFF);
        chk("f2_addr3",     wl_addr[7], 3);
`ifdef DECRYPT_SEQ_STALL_CNT_EN
        chk("f2_stall_hold", if0.stall_cnt, 3);
`endif
        chk("rd_wr_overlap", ov0, 0);

        // frame 3: reset while in XOR at addr 2
        ks_r5a = 1'b0;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int i = 0; i < 50 && !(if0.mem_rd_en && if0.mem_rd_addr == 2'd2); i++) step();
        chk("f3_reach_rd2", if0.mem_rd_en && (if0.mem_rd_addr == 2'd2), 1);
        step();
        chk("f3_in_xor", if0.ks_ready, 1);
        wbase = wn0;
        rst = 1'b1;
        #1;
        chk("f3_rst_ready", if0.ks_ready, 0);
        chk("f3_rst_busy",  if0.busy, 0);
        chk("f3_rst_wr_en", if0.mem_wr_en, 0);
        chk("f3_rst_rd_en", if0.mem_rd_en, 0);
        chk("f3_rst_done",  if0.done, 0);
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("f3_no_writes", wn0, wbase);
        chk("f3_idle_busy", if0.busy, 0);
        chk("f3_idle_done", if0.done, 0);

        // WARMUP=0 instance: SEED goes straight to RD
        if1.seed_in = 32'h00000001;
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        chk("w0_seed_load", if1.seed_load, 1);
        step();
        chk("w0_rd_en",    if1.mem_rd_en, 1);
        chk("w0_rd_addr",  if1.mem_rd_addr, 0);
        chk("w0_no_ready", if1.ks_ready, 0);
        for (int i = 0; i < 50 && !if1.done; i++) step();
        chk("w0_done",     if1.done, 1);
        chk("w0_wr_count", wn1, 4);
        chk("w0_first_addr", f1_addr, 0);
        chk("w0_first_r",  f1_r, 8'hB0);
        chk("w0_first_g",  f1_g, 8'h20);
        chk("w0_first_b",  f1_b, 8'hD0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
